baud_rate_generator: RTL and testbench
======================================

# baud_rate_generator

Turns the 16-bit divisor from the configuration register file into single-cycle timing strobes for the UART datapath. It sits between the configuration registers and the transmitter/receiver. It produces three kinds of strobe:
- a 16x oversampling tick;
- a bit-rate tick for the transmitter;
- a mid-bit sample strobe and a bit-end strobe for the receiver, re-phased on start-bit detection.

## Interface
Parameters:
- `OVERSAMPLE`, 16: oversampling ticks per bit; power of two, 4..16.

Ports:
- `clk_i`  in  1  system clock
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `divisor_i`  in  16  divisor value from the configuration registers; oversampling period in clocks
- `reset_bd_gen_i`  in  1  synchronous restart; loads `divisor_i` and clears all counters
- `tx_enable_i`  in  1  transmitter enabled; when low, TX phase is held at 0
- `rx_enable_i`  in  1  receiver enabled; when low, RX phase is held at 0
- `rx_resync_i`  in  1  receiver detected a start-bit edge; restart RX bit phase
- `ov_tick_o`  out  1  oversampling strobe, 1 clock wide
- `tx_tick_o`  out  1  transmitter bit strobe, 1 clock wide
- `rx_sample_o`  out  1  receiver mid-bit sample strobe
- `rx_bit_end_o`  out  1  receiver bit-boundary strobe
- `active_divisor_o`  out  16  divisor currently in use, for debug and status

## Operation
- Registers:
  - `active_div` [15:0]: reset value `STD_DIVISOR`.
  - `div_cnt` [15:0]: counts up 0..`active_div`-1; reset value 0.
  - `tx_phase` and `rx_phase` [log2(OVERSAMPLE)-1:0]: reset value 0.
- Internal terminal event `ov_ev` = (`div_cnt` == `active_div`-1) & (`active_div` != 0). It is combinational.
- On `ov_ev`:
  - `div_cnt` <= 0.
  - `active_div` <= `divisor_i`. A new divisor takes effect only at a period boundary, so no runt periods occur.
- Without `ov_ev`, `div_cnt` increments.
- When `active_div` == 0, the generator is halted: `div_cnt` is held at 0 and no strobes are produced until a restart or reset loads a non-zero value.
- `active_div` == 1 makes `ov_ev` true every clock, so `ov_tick_o` stays continuously high.
- TX path:
  - If `tx_enable_i` is low, `tx_phase` <= 0 and `tx_tick_o` <= 0.
  - Otherwise, on `ov_ev`, `tx_phase` increments and wraps at `OVERSAMPLE`-1 to 0.
  - `tx_tick_o` <= `ov_ev` & (`tx_phase` == `OVERSAMPLE`-1).
- RX path:
  - If `rx_enable_i` is low, `rx_phase` <= 0.
  - If `rx_resync_i` is high, `rx_phase` <= 0 and no RX strobe is issued that cycle. `rx_resync_i` wins over a coincident `ov_ev`.
  - Otherwise, on `ov_ev`, `rx_phase` increments with wrap.
  - `rx_sample_o` <= `ov_ev` & (`rx_phase` == `OVERSAMPLE`/2-1).
  - `rx_bit_end_o` <= `ov_ev` & (`rx_phase` == `OVERSAMPLE`-1).
- `reset_bd_gen_i` has the highest synchronous priority:
  - `active_div` <= `divisor_i`.
  - `div_cnt`, `tx_phase` and `rx_phase` <= 0.
  - All strobe outputs <= 0 on that edge.
- `ov_tick_o` <= `ov_ev`, gated by "not `reset_bd_gen_i`".
- `active_divisor_o` = `active_div`.

## Timing
- All strobe outputs are registered and aligned: each is asserted in the cycle after the edge at which `ov_ev` was true.
- Reset values: all strobes 0; `active_divisor_o` = `STD_DIVISOR`.
- After reset release, or after a restart with divisor N ≥ 1:
  - The first `ov_tick_o` is high in clock cycle N after the release or restart edge.
  - `ov_tick_o` then repeats with period exactly N clocks.
- `tx_tick_o` period is N·`OVERSAMPLE` clocks. It coincides with every `OVERSAMPLE`-th `ov_tick_o`.
- After `rx_resync_i` is sampled:
  - `rx_sample_o` coincides with the `OVERSAMPLE`/2-th following `ov_tick_o`.
  - `rx_bit_end_o` coincides with the `OVERSAMPLE`-th following `ov_tick_o`.
- A `divisor_i` change without a restart takes effect after the current period completes, i.e. one period of latency.
- An asynchronous reset mid-period returns all registers to their reset values immediately. There is no pending-strobe carry-over.

## Structure
- Shared package `uart_pkg`:
  - reuses `STD_DIVISOR`;
  - adds `OVERSAMPLE_RATE` = 16 as the parameter default;
  - adds `RX_SAMPLE_PHASE` = `OVERSAMPLE`/2-1.
- One natural sub-module, `tick_phase_counter`, instantiated twice (TX and RX):
  - inputs: `clk_i`, `rst_n_i`, enable, clear, tick;
  - outputs: phase, wrap flag.

## Test plan
- Reset, then divisor held at `STD_DIVISOR` = 10 → first `ov_tick_o` in cycle 10; ticks every 10 clocks; `tx_tick_o` every 160 clocks.
- Restart with `divisor_i` = 3, `tx_enable_i` high → `ov_tick_o` in cycles 3, 6, 9…; `tx_tick_o` first in cycle 48; `active_divisor_o` = 3.
- `divisor_i` changed 5→7 mid-period without a restart → the current period finishes at 5 clocks, the next period is 7 clocks, and no short pulse appears.
- Divisor 4, `rx_enable_i` high, `rx_resync_i` pulsed coincident with an `ov_ev` → no strobe that cycle; `rx_sample_o` after 8 further ov ticks (32 clocks); `rx_bit_end_o` after 16 (64 clocks).
- Divisor 0 loaded by restart → no strobes for 1000 cycles; restart with divisor 1 → `ov_tick_o` continuously high.
- `tx_enable_i` dropped at `tx_phase` 9, then raised → the next `tx_tick_o` is a full 16 ov ticks after re-enable; assert `rst_n_i` mid-period → all strobes 0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: default baud divisor, oversampling rate and RX sample phase.
package uart_pkg;

    localparam logic [15:0] STD_DIVISOR     = 16'd10;
    localparam int unsigned OVERSAMPLE_RATE = 16;
    localparam int unsigned RX_SAMPLE_PHASE = OVERSAMPLE_RATE / 2 - 1;

    // Mid-bit phase for an arbitrary oversampling rate.
    function automatic int unsigned rx_sample_phase(input int unsigned oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/tick_phase_counter.sv
// Counts oversampling ticks within one bit period and flags the last tick of the bit.
module tick_phase_counter #(
    parameter  int unsigned OVERSAMPLE = 16,
    localparam int unsigned PhaseW     = $clog2(OVERSAMPLE)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              tick_i,
    output logic [PhaseW-1:0] phase_o,
    output logic              wrap_o
);

    localparam logic [PhaseW-1:0] PhaseMax = PhaseW'(OVERSAMPLE - 1);

    logic [PhaseW-1:0] phase_q, phase_d;

    // OVERSAMPLE is a power of two, so the natural overflow is the wrap.
    always_comb begin
        phase_d = phase_q;
        if (clear_i || !enable_i) begin
            phase_d = '0;
        end else if (tick_i) begin
            phase_d = phase_q + PhaseW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;
    assign wrap_o  = enable_i & ~clear_i & tick_i & (phase_q == PhaseMax);

endmodule

// File: rtl/baud_rate_generator.sv
// Divides the system clock into oversampling, TX bit and RX sample/bit-end strobes.
module baud_rate_generator
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_RATE
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] divisor_i,
    input  logic        reset_bd_gen_i,
    input  logic        tx_enable_i,
    input  logic        rx_enable_i,
    input  logic        rx_resync_i,
    output logic        ov_tick_o,
    output logic        tx_tick_o,
    output logic        rx_sample_o,
    output logic        rx_bit_end_o,
    output logic [15:0] active_divisor_o
);

    localparam int unsigned       PhaseW      = $clog2(OVERSAMPLE);
    localparam logic [PhaseW-1:0] SamplePhase = PhaseW'(rx_sample_phase(OVERSAMPLE));

    logic [15:0]       active_div_q, active_div_d;
    logic [15:0]       div_cnt_q, div_cnt_d;
    logic              ov_ev;
    logic              rx_clear;
    logic [PhaseW-1:0] tx_phase, rx_phase;
    logic              tx_wrap, rx_wrap;
    logic              ov_tick_q, tx_tick_q, rx_sample_q, rx_bit_end_q;
    logic              ov_tick_d, tx_tick_d, rx_sample_d, rx_bit_end_d;
    logic              unused_tx_phase;

    assign ov_ev = (active_div_q != '0) && (div_cnt_q == active_div_q - 16'd1);

    // New divisors are only picked up at a period boundary, so periods are never cut short.
    always_comb begin
        active_div_d = active_div_q;
        div_cnt_d    = div_cnt_q + 16'd1;
        if (reset_bd_gen_i || ov_ev) begin
            active_div_d = divisor_i;
            div_cnt_d    = '0;
        end else if (active_div_q == '0) begin
            div_cnt_d = '0;
        end
    end

    assign rx_clear = reset_bd_gen_i | rx_resync_i;

    tick_phase_counter #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tx_phase (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .enable_i(tx_enable_i),
        .clear_i (reset_bd_gen_i),
        .tick_i  (ov_ev),
        .phase_o (tx_phase),
        .wrap_o  (tx_wrap)
    );

    tick_phase_counter #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_rx_phase (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .enable_i(rx_enable_i),
        .clear_i (rx_clear),
        .tick_i  (ov_ev),
        .phase_o (rx_phase),
        .wrap_o  (rx_wrap)
    );

    assign unused_tx_phase = ^tx_phase;

    always_comb begin
        ov_tick_d    = ov_ev & ~reset_bd_gen_i;
        tx_tick_d    = tx_wrap;
        rx_sample_d  = ov_ev & rx_enable_i & ~rx_clear & (rx_phase == SamplePhase);
        rx_bit_end_d = rx_wrap;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_div_q <= STD_DIVISOR;
            div_cnt_q    <= '0;
            ov_tick_q    <= 1'b0;
            tx_tick_q    <= 1'b0;
            rx_sample_q  <= 1'b0;
            rx_bit_end_q <= 1'b0;
        end else begin
            active_div_q <= active_div_d;
            div_cnt_q    <= div_cnt_d;
            ov_tick_q    <= ov_tick_d;
            tx_tick_q    <= tx_tick_d;
            rx_sample_q  <= rx_sample_d;
            rx_bit_end_q <= rx_bit_end_d;
        end
    end

    assign ov_tick_o        = ov_tick_q;
    assign tx_tick_o        = tx_tick_q;
    assign rx_sample_o      = rx_sample_q;
    assign rx_bit_end_o     = rx_bit_end_q;
    assign active_divisor_o = active_div_q;

endmodule

// File: tb/tb_baud_rate_generator.sv
// Scoreboard bench for baud_rate_generator: expected strobe cycles queued, monitor compares.
module tb_baud_rate_generator;

    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] divisor;
    logic        reset_bd_gen, tx_en, rx_en, rx_resync;
    logic        ov_tick, tx_tick, rx_sample, rx_bit_end;
    logic [15:0] active_div;

    baud_rate_generator #(
        .OVERSAMPLE(OS)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .divisor_i       (divisor),
        .reset_bd_gen_i  (reset_bd_gen),
        .tx_enable_i     (tx_en),
        .rx_enable_i     (rx_en),
        .rx_resync_i     (rx_resync),
        .ov_tick_o       (ov_tick),
        .tx_tick_o       (tx_tick),
        .rx_sample_o     (rx_sample),
        .rx_bit_end_o    (rx_bit_end),
        .active_divisor_o(active_div)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] vec;  // {ov, tx, rx_sample, rx_bit_end}
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe observed must match the head of the queue.
    always @(negedge clk) begin
        logic [3:0] v;
        exp_t       e;
        v = {ov_tick, tx_tick, rx_sample, rx_bit_end};
        if (v != 4'b0000) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: cycle %0d strobes %b, expected none", cyc, v);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.vec != v) begin
                    n_err++;
                    $display("FAIL strobe: cycle %0d strobes %b, expected cycle %0d strobes %b",
                             cyc, v, e.cyc, e.vec);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    // Queue kmax ov ticks of period per after base; rx phase restarted after tick koff.
    task automatic push_run(input int base, input int per, input int kmax, input bit tx,
                            input bit rx, input int koff);
        logic [3:0] v;
        int         j;
        for (int k = 1; k <= kmax; k++) begin
            v = 4'b1000;
            if (tx && (k % OS == 0)) v[2] = 1'b1;
            if (rx && k > koff) begin
                j = k - koff;
                if (j % OS == OS / 2) v[1] = 1'b1;
                if (j % OS == 0) v[0] = 1'b1;
            end
            push(base + per * k, v);
        end
    endtask

    task automatic drain(input string name);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    // Restart held for two edges; p is the cycle index of the last restart edge.
    task automatic restart(input logic [15:0] div, output int p);
        divisor      = div;
        reset_bd_gen = 1'b1;
        step();
        step();
        reset_bd_gen = 1'b0;
        p = cyc;
        drain("drain_before_restart");
        check("active_divisor_after_restart", int'(active_div), int'(div));
    endtask

    initial begin
        int p;
        divisor      = 16'd10;
        reset_bd_gen = 1'b0;
        tx_en        = 1'b1;
        rx_en        = 1'b1;
        rx_resync    = 1'b0;
        rst_n        = 1'b0;
        repeat (3) step();
        check("reset_strobes", int'({ov_tick, tx_tick, rx_sample, rx_bit_end}), 0);
        check("reset_active_divisor", int'(active_div), 10);

        // Default divisor 10 straight out of reset, TX and RX running.
        rst_n = 1'b1;
        p     = cyc;
        push_run(p, 10, 32, 1'b1, 1'b1, 0);
        wait_until(p + 325);

        // Divisor 3, TX only: first tx tick at cycle 48.
        rx_en = 1'b0;
        restart(16'd3, p);
        push_run(p, 3, 32, 1'b1, 1'b0, 0);
        wait_until(p + 97);

        // 5 -> 7 change mid-period takes effect one period later.
        tx_en = 1'b0;
        restart(16'd5, p);
        push(p + 5, 4'b1000);
        push(p + 10, 4'b1000);
        push(p + 15, 4'b1000);
        push(p + 22, 4'b1000);
        push(p + 29, 4'b1000);
        push(p + 36, 4'b1000);
        wait_until(p + 12);
        check("active_divisor_before_change", int'(active_div), 5);
        divisor = 16'd7;
        wait_until(p + 16);
        check("active_divisor_after_change", int'(active_div), 7);
        wait_until(p + 40);

        // Divisor 4, resync coincident with the 5th ov event.
        rx_en = 1'b1;
        restart(16'd4, p);
        push_run(p, 4, 22, 1'b0, 1'b1, 5);
        wait_until(p + 19);
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        wait_until(p + 90);

        // Divisor 0 halts everything, then divisor 1 ticks every clock.
        rx_en = 1'b0;
        tx_en = 1'b1;
        restart(16'd0, p);
        wait_until(p + 1000);
        restart(16'd1, p);
        push_run(p, 1, 40, 1'b1, 1'b0, 0);
        wait_until(p + 40);

        // Divisor 2: TX disabled at phase 9, re-enabled, then async reset mid-stream.
        restart(16'd2, p);
        for (int k = 1; k <= 29; k++) push(p + 2 * k, (k == 28) ? 4'b1100 : 4'b1000);
        wait_until(p + 18);
        tx_en = 1'b0;
        wait_until(p + 24);
        tx_en = 1'b1;
        wait_until(p + 60);
        check("ov_tick_before_async_reset", int'(ov_tick), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_strobes", int'({ov_tick, tx_tick, rx_sample, rx_bit_end}), 0);
        check("async_reset_active_divisor", int'(active_div), 10);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        drain("drain_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
